// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin arbiter sharing one single-port RAM between an SPI command stream and a host port
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [9:0]           rx_data,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 spi_ovf
);
  typedef enum logic [1:0] {IDLE, SPI_ACC, HOST_ACC, RD_WAIT} state_t;
  state_t state, state_nx;
  logic                 pend_v;
  logic [1:0]           pend_cmd;
  logic [7:0]           pend_data;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 rr_host, rd_host;
  logic                 spi_req, addr_cmd, retire;
  assign spi_req  = pend_v && pend_cmd[0];
  assign addr_cmd = pend_v && !pend_cmd[0] && state == IDLE;
  assign retire   = addr_cmd || state == SPI_ACC;
  // Next state and RAM/grant outputs; SPI wins a conflict unless the pointer favours the host
  always_comb begin
    state_nx  = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    host_gnt  = 1'b0;
    case (state)
      IDLE: begin
        if (spi_req && (!host_req || !rr_host)) state_nx = SPI_ACC;
        else if (host_req) state_nx = HOST_ACC;
      end
      SPI_ACC: begin
        ram_en    = 1'b1;
        ram_we    = !pend_cmd[1];
        ram_addr  = pend_cmd[1] ? rd_addr : wr_addr;
        ram_wdata = pend_data;
        state_nx  = pend_cmd[1] ? RD_WAIT : IDLE;
      end
      HOST_ACC: begin
        ram_en    = 1'b1;
        host_gnt  = 1'b1;
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        state_nx  = host_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // State, pending SPI frame, address pointers, arbitration pointer and read-return registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_v      <= 1'b0;
      pend_cmd    <= '0;
      pend_data   <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rr_host     <= 1'b0;
      rd_host     <= 1'b0;
      spi_ovf     <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nx;
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      if (rx_valid && pend_v && !retire) spi_ovf <= 1'b1;
      if (rx_valid && (!pend_v || retire)) begin
        pend_v    <= 1'b1;
        pend_cmd  <= rx_data[9:8];
        pend_data <= rx_data[7:0];
      end else if (retire) pend_v <= 1'b0;
      if (addr_cmd && pend_cmd[1]) rd_addr <= ADDR_SIZE'(pend_data);
      if (addr_cmd && !pend_cmd[1]) wr_addr <= ADDR_SIZE'(pend_data);
      if (state == SPI_ACC && !pend_cmd[1])
        wr_addr <= (wr_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : wr_addr + 1'b1;
      if (state == IDLE && state_nx == SPI_ACC) rr_host <= 1'b1;
      if (state == IDLE && state_nx == HOST_ACC) rr_host <= 1'b0;
      if (state == SPI_ACC) rd_host <= 1'b0;
      if (state == HOST_ACC) rd_host <= 1'b1;
      if (state == RD_WAIT && rd_host) begin
        host_rdata  <= ram_rdata;
        host_rvalid <= 1'b1;
      end
      if (state == RD_WAIT && !rd_host) begin
        tx_data  <= ram_rdata;
        tx_valid <= 1'b1;
      end
    end
  end
endmodule
